// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler driving the select of an 8-to-1 mux, with a bounded
// burst per owner whenever another requester is waiting.
module mux8_rr_scheduler #(
  parameter int unsigned BURST = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_req,
  input  logic       i_ready,
  output logic [7:0] o_gnt,
  output logic [2:0] o_s,
  output logic       o_valid,
  output logic       o_owner_last
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

  state_t     r_state;
  logic [7:0] r_gnt;
  logic [2:0] r_s;
  logic       r_valid;
  logic       r_ownerLast;
  logic [2:0] r_ptr;
  logic [3:0] r_cnt;

  logic       w_xfer;
  logic [7:0] w_others;
  logic       w_anyOther;
  logic       w_burstEnd;
  logic       w_release;
  logic [2:0] w_nextPtr;
  logic [3:0] w_idleScan;
  logic [3:0] w_handScan;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 8.
  function automatic logic [3:0] scanFrom(input logic [7:0] req, input logic [2:0] start);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = start + 3'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    w_xfer     = r_valid & i_ready;
    w_others   = i_req & ~r_gnt;
    w_anyOther = |w_others;
    w_burstEnd = w_xfer && (r_cnt == LAST_CNT);
    w_release  = !i_req[r_s] || (w_burstEnd && w_anyOther);
    w_nextPtr  = r_s + 3'd1;
    w_idleScan = scanFrom(i_req, r_ptr);
    w_handScan = scanFrom(w_others, w_nextPtr);
  end

  // On release the owner is excluded from the handover scan, so a burst-limited
  // owner cannot immediately win again; a lone owner just restarts its count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= 8'd0;
      r_s         <= 3'd0;
      r_valid     <= 1'b0;
      r_ownerLast <= 1'b0;
      r_ptr       <= 3'd0;
      r_cnt       <= 4'd0;
    end else begin
      r_ownerLast <= (r_state == GRANT) && w_burstEnd && w_anyOther;
      case (r_state)
        IDLE: begin
          if (w_idleScan[3]) begin
            r_state <= GRANT;
            r_gnt   <= 8'b1 << w_idleScan[2:0];
            r_s     <= w_idleScan[2:0];
            r_valid <= 1'b1;
            r_cnt   <= 4'd0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr <= w_nextPtr;
            r_cnt <= 4'd0;
            if (w_handScan[3]) begin
              r_gnt <= 8'b1 << w_handScan[2:0];
              r_s   <= w_handScan[2:0];
            end else begin
              r_state <= IDLE;
              r_gnt   <= 8'd0;
              r_s     <= 3'd0;
              r_valid <= 1'b0;
            end
          end else if (w_xfer) begin
            r_cnt <= w_burstEnd ? 4'd0 : r_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_s          = r_s;
  assign o_valid      = r_valid;
  assign o_owner_last = r_ownerLast;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed scoreboard bench for mux8_rr_scheduler: expected outputs are queued
// as each step is driven and compared just after the following clock edge.
module tb_mux8_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ready;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       valid;
  logic       ownerLast;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] s;
    logic       valid;
    logic       last;
    string      tag;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  mux8_rr_scheduler #(.BURST(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_ready     (ready),
    .o_gnt       (gnt),
    .o_s         (s),
    .o_valid     (valid),
    .o_owner_last(ownerLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] idxOf(input logic [7:0] g);
    for (int i = 0; i < 8; i++) begin
      if (g[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic checkField(input string tag, input string name,
                            input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, expv);
    end
  endtask

  task automatic pushExpected(input logic [7:0] eg, input logic ev, input logic el,
                              input string tag);
    expQ.push_back('{gnt: eg, s: idxOf(eg), valid: ev, last: el, tag: tag});
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = expQ.pop_front();
      checkField(e.tag, "gnt",   gnt,             e.gnt);
      checkField(e.tag, "s",     8'(s),           8'(e.s));
      checkField(e.tag, "valid", 8'(valid),       8'(e.valid));
      checkField(e.tag, "last",  8'(ownerLast),   8'(e.last));
    end
  endtask

  // One clock step: drive inputs away from the edge, queue what must appear after it.
  task automatic applyStimulus(input logic [7:0] r, input logic rdy,
                               input logic [7:0] eg, input logic ev, input logic el,
                               input string tag);
    @(negedge clk);
    req   = r;
    ready = rdy;
    pushExpected(eg, ev, el, tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge clk);
    req   = 8'h00;
    ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pushExpected(8'h00, 1'b0, 1'b0, "reset_hold");
    checkOutput();

    @(negedge clk);
    rst_n = 1'b1;
    pushExpected(8'h01, 1'b1, 1'b0, "reset_release");
    @(posedge clk);
    #1;
    checkOutput();
    applyStimulus(8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, "reset_stall_hold");

    doReset();
    for (int i = 0; i < 10; i++)
      applyStimulus(8'h20, 1'b1, 8'h20, 1'b1, 1'b0, $sformatf("single_%0d", i));

    doReset();
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b0, "rot_a1");
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b0, "rot_a2");
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b0, "rot_a3");
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b0, "rot_a4");
    applyStimulus(8'h81, 1'b1, 8'h80, 1'b1, 1'b1, "rot_b1");
    applyStimulus(8'h81, 1'b1, 8'h80, 1'b1, 1'b0, "rot_b2");
    applyStimulus(8'h81, 1'b1, 8'h80, 1'b1, 1'b0, "rot_b3");
    applyStimulus(8'h81, 1'b1, 8'h80, 1'b1, 1'b0, "rot_b4");
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b1, "rot_wrap");
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b0, "rot_wrap2");

    doReset();
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b0, "stall_grant");
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b0, "stall_x1");
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b0, "stall_x2");
    applyStimulus(8'h81, 1'b0, 8'h01, 1'b1, 1'b0, "stall_w1");
    applyStimulus(8'h81, 1'b0, 8'h01, 1'b1, 1'b0, "stall_w2");
    applyStimulus(8'h81, 1'b0, 8'h01, 1'b1, 1'b0, "stall_w3");
    applyStimulus(8'h81, 1'b1, 8'h01, 1'b1, 1'b0, "stall_x3");
    applyStimulus(8'h81, 1'b1, 8'h80, 1'b1, 1'b1, "stall_x4_handover");

    doReset();
    applyStimulus(8'h0C, 1'b1, 8'h04, 1'b1, 1'b0, "early_grant");
    applyStimulus(8'h0C, 1'b1, 8'h04, 1'b1, 1'b0, "early_x1");
    applyStimulus(8'h08, 1'b1, 8'h08, 1'b1, 1'b0, "early_handover");
    applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "early_idle");
    applyStimulus(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "early_idle2");

    doReset();
    applyStimulus(8'h20, 1'b1, 8'h20, 1'b1, 1'b0, "midrst_grant");
    applyStimulus(8'h20, 1'b1, 8'h20, 1'b1, 1'b0, "midrst_x1");
    #2;
    rst_n = 1'b0;
    #1;
    pushExpected(8'h00, 1'b0, 1'b0, "midrst_async");
    checkOutput();
    @(negedge clk);
    req   = 8'h00;
    rst_n = 1'b1;
    applyStimulus(8'h21, 1'b1, 8'h01, 1'b1, 1'b0, "midrst_ptr0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
